stream_demux_1_n: RTL and testbench

//  Parametrised 1-to-NUM_OUT demultiplexer with valid/ready handshake on input and every output.

---
 rtl/demux_pkg.sv | 25 ++
 rtl/demux_slot.sv | 43 ++++
 rtl/stream_demux_1_n.sv | 76 +++++++
 tb/tb_stream_demux_1_n.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: default sizes, select-width helper
// and a slice macro for channel-flattened buses.
`ifndef DEMUX_PKG_SV
`define DEMUX_PKG_SV

// Channel i of a flattened bus; expects DATA_WIDTH in the using scope.
`define CH_SLICE(i) ((i)*DATA_WIDTH) +: DATA_WIDTH

package demux_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_OUT    = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned w = 0; w < 32; w++) begin
      if ((33'd1 << w) < {1'b0, value}) result = w + 1;
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/demux_slot.sv
// One-entry registered output slot: holds a word until the consumer takes it,
// and may be reloaded in the same cycle it drains.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // The parent only asserts load_i when the slot is empty or draining this cycle.
  always_comb begin
    valid_d = valid_q & ~ready_i;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_in_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demux_1_n.sv
// 1-to-NUM_OUT valid/ready demultiplexer with registered per-channel slots,
// all-or-none broadcast and discard of out-of-range selects.
module stream_demux_1_n
  import demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_OUT    = DEF_NUM_OUT,
  parameter int unsigned SEL_W      = clog2(NUM_OUT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]              in_sel,
  input  logic                          in_bcast,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic                          drop_pulse
);

  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] load;
  logic               sel_ok;
  logic               sel_free;
  logic               accept;
  logic               drop_d, drop_q;

  assign free   = ~out_valid | out_ready;
  assign sel_ok = {1'b0, in_sel} < (SEL_W + 1)'(NUM_OUT);

  // Out-of-range selects are always accepted so they can be discarded.
  always_comb begin
    sel_free = 1'b0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (in_sel == SEL_W'(i)) sel_free = free[i];
    end
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = sel_free;
    else             in_ready = 1'b1;
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      load[i] = accept & (in_bcast | (in_sel == SEL_W'(i)));
    end
  end

  assign drop_d = accept & ~in_bcast & ~sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= drop_d;
  end

  assign drop_pulse = drop_q;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    demux_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load[g]),
      .data_in_i(in_data),
      .ready_i  (out_ready[g]),
      .valid_o  (out_valid[g]),
      .data_o   (out_data[`CH_SLICE(g)])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Directed and randomized checks of stream_demux_1_n at NUM_OUT=4 and NUM_OUT=5.
module tb_stream_demux_1_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid4, in_bcast4, in_ready4, drop4;
  logic [1:0]  in_sel4;
  logic [7:0]  in_data4;
  logic [3:0]  out_ready4, out_valid4;
  logic [31:0] out_data4;

  logic        in_valid5, in_bcast5, in_ready5, drop5;
  logic [2:0]  in_sel5;
  logic [7:0]  in_data5;
  logic [4:0]  out_ready5, out_valid5;
  logic [39:0] out_data5;

  int total = 0;
  int bad   = 0;

  logic [7:0] q [4][$];

  stream_demux_1_n #(.DATA_WIDTH(8), .NUM_OUT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_sel(in_sel4), .in_bcast(in_bcast4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .drop_pulse(drop4)
  );

  stream_demux_1_n #(.DATA_WIDTH(8), .NUM_OUT(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data(in_data5), .in_sel(in_sel5), .in_bcast(in_bcast5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .drop_pulse(drop5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_v, exp_free;
    logic       exp_rdy;

    rst_n = 1'b0;
    in_valid4 = 0; in_bcast4 = 0; in_sel4 = '0; in_data4 = '0; out_ready4 = '1;
    in_valid5 = 0; in_bcast5 = 0; in_sel5 = '0; in_data5 = '0; out_ready5 = '1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset during traffic
    out_ready4 = 4'b0000; in_valid4 = 1; in_sel4 = 2'd0; in_data4 = 8'h5A;
    out_ready5 = 5'b00000; in_valid5 = 1; in_sel5 = 3'd4; in_data5 = 8'hC3;
    tick();
    chk("pre_rst_valid4", 64'(out_valid4), 64'h1);
    chk("pre_rst_valid5", 64'(out_valid5), 64'h10);
    in_sel5 = 3'd7; in_data5 = 8'hFF;
    tick();
    chk("pre_rst_drop5", 64'(drop5), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid4", 64'(out_valid4), 64'h0);
    chk("rst_data4", 64'(out_data4), 64'h0);
    chk("rst_valid5", 64'(out_valid5), 64'h0);
    chk("rst_data5", 64'(out_data5), 64'h0);
    chk("rst_drop5", 64'(drop5), 64'h0);
    tick();
    in_valid4 = 0; in_valid5 = 0; in_sel5 = '0;
    rst_n = 1'b1;
    tick();
    in_bcast4 = 1; #1;
    chk("post_rst_ready_bcast", 64'(in_ready4), 64'h1);
    in_bcast4 = 0; in_sel4 = 2'd3; #1;
    chk("post_rst_ready_uni", 64'(in_ready4), 64'h1);

    // Unicast stream
    out_ready4 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid4 = 1; in_sel4 = 2'(i); in_data4 = 8'hA0 + 8'(i);
      #1;
      chk("uni_ready", 64'(in_ready4), 64'h1);
      tick();
      chk("uni_valid", 64'(out_valid4), 64'(1 << i));
      chk("uni_data", 64'(out_data4[i*8 +: 8]), 64'(8'hA0 + 8'(i)));
    end
    in_valid4 = 0;
    tick();
    chk("uni_drained", 64'(out_valid4), 64'h0);

    // Back-pressure on channel 2
    out_ready4 = 4'b1011; in_valid4 = 1; in_sel4 = 2'd2; in_data4 = 8'h55;
    #1;
    chk("bp_ready_first", 64'(in_ready4), 64'h1);
    tick();
    chk("bp_valid_first", 64'(out_valid4), 64'h4);
    in_data4 = 8'h66;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp_ready_blocked", 64'(in_ready4), 64'h0);
      tick();
      chk("bp_hold_valid", 64'(out_valid4), 64'h4);
      chk("bp_hold_data", 64'(out_data4[23:16]), 64'h55);
    end
    out_ready4 = 4'hF;
    #1;
    chk("bp_ready_released", 64'(in_ready4), 64'h1);
    tick();
    chk("bp_refill_valid", 64'(out_valid4), 64'h4);
    chk("bp_refill_data", 64'(out_data4[23:16]), 64'h66);
    in_valid4 = 0;
    tick();
    chk("bp_drained", 64'(out_valid4), 64'h0);

    // Broadcast blocked by a full channel, then all-at-once
    out_ready4 = 4'b1101; in_valid4 = 1; in_sel4 = 2'd1; in_data4 = 8'h11;
    tick();
    in_bcast4 = 1; in_data4 = 8'h3C;
    #1;
    chk("bc_ready_blocked", 64'(in_ready4), 64'h0);
    tick();
    chk("bc_no_partial", 64'(out_valid4), 64'h2);
    chk("bc_ch1_kept", 64'(out_data4[15:8]), 64'h11);
    out_ready4 = 4'hF;
    #1;
    chk("bc_ready_released", 64'(in_ready4), 64'h1);
    tick();
    chk("bc_all_valid", 64'(out_valid4), 64'hF);
    chk("bc_all_data", 64'(out_data4), 64'h3C3C3C3C);
    in_valid4 = 0; in_bcast4 = 0;
    tick();
    chk("bc_drained", 64'(out_valid4), 64'h0);

    // Out-of-range select on the 5-channel instance
    out_ready5 = 5'h1F; in_valid5 = 1; in_sel5 = 3'd7; in_data5 = 8'hFF;
    #1;
    chk("oor_ready", 64'(in_ready5), 64'h1);
    tick();
    chk("oor_drop", 64'(drop5), 64'h1);
    chk("oor_no_valid", 64'(out_valid5), 64'h0);
    in_sel5 = 3'd4; in_data5 = 8'h44;
    tick();
    chk("oor_drop_cleared", 64'(drop5), 64'h0);
    chk("last_ch_valid", 64'(out_valid5), 64'h10);
    chk("last_ch_data", 64'(out_data5[39:32]), 64'h44);
    in_valid5 = 0;
    tick();
    chk("last_ch_drop_none", 64'(drop5), 64'h0);

    // Randomized traffic against per-channel FIFO scoreboard
    for (int n = 0; n < 3000; n++) begin
      in_valid4 = ($urandom_range(0, 3) != 0);
      in_sel4   = 2'($urandom_range(0, 3));
      in_bcast4 = ($urandom_range(0, 7) == 0);
      in_data4  = 8'($urandom);
      for (int c = 0; c < 4; c++) out_ready4[c] = ($urandom_range(0, 9) < 7);
      #1;
      for (int c = 0; c < 4; c++) begin
        exp_v[c]    = (q[c].size() != 0);
        exp_free[c] = !exp_v[c] || out_ready4[c];
      end
      exp_rdy = in_bcast4 ? (&exp_free) : exp_free[in_sel4];
      chk("rnd_in_ready", 64'(in_ready4), 64'(exp_rdy));
      chk("rnd_out_valid", 64'(out_valid4), 64'(exp_v));
      for (int c = 0; c < 4; c++) begin
        if (exp_v[c]) chk("rnd_out_data", 64'(out_data4[c*8 +: 8]), 64'(q[c][0]));
      end
      @(posedge clk);
      for (int c = 0; c < 4; c++) begin
        if (exp_v[c] && out_ready4[c]) void'(q[c].pop_front());
      end
      if (in_valid4 && exp_rdy) begin
        if (in_bcast4) begin
          for (int c = 0; c < 4; c++) q[c].push_back(in_data4);
        end else begin
          q[in_sel4].push_back(in_data4);
        end
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
